// File: rtl/mod_phase_meter.sv
// mod_phase_meter: measures mod-rise to echo-rise delay in clk cycles and averages 2**AVG_LOG2 samples
module mod_phase_meter #(
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 15000,
   parameter int AVG_LOG2    = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mod,
   input  logic             echo_in,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_data,
   output logic             res_valid,
   output logic             res_timeout,
   output logic             busy
);
   typedef enum logic [1:0] {ARMED, COUNT, ACCUM, PRESENT} state_t;
   localparam logic [AVG_LOG2:0] NSAMP = (AVG_LOG2+1)'(1 << AVG_LOG2);
   localparam logic [CNT_W-1:0]  TMAX  = CNT_W'(TIMEOUT);
   state_t                    state, state_nxt;
   logic [SYNC_STAGES-1:0]    sync;
   logic                      echo_s_q, mod_q, flag;
   logic [CNT_W-1:0]          cnt, sample;
   logic [CNT_W+AVG_LOG2-1:0] acc, acc_nxt;
   logic [AVG_LOG2:0]         n, n_inc;
   logic                      mod_rise, echo_rise, expire, full;
   assign busy = state == COUNT;
   always_comb begin
      mod_rise  = mod & ~mod_q;
      echo_rise = sync[SYNC_STAGES-1] & ~echo_s_q;
      // a second mod edge before the echo is a missed echo, same as running out of time
      expire    = (cnt == TMAX) | mod_rise;
      acc_nxt   = acc + (CNT_W+AVG_LOG2)'(sample);
      n_inc     = n + (AVG_LOG2+1)'(1);
      full      = n_inc == NSAMP;
      state_nxt = state;
      case (state)
         ARMED:   state_nxt = mod_rise ? COUNT : ARMED;
         COUNT:   state_nxt = (echo_rise | expire) ? ACCUM : COUNT;
         ACCUM:   state_nxt = full ? PRESENT : ARMED;
         default: state_nxt = res_ready ? ARMED : PRESENT;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ARMED;
         sync        <= '0;
         echo_s_q    <= 1'b0;
         mod_q       <= 1'b0;
         flag        <= 1'b0;
         cnt         <= '0;
         sample      <= '0;
         acc         <= '0;
         n           <= '0;
         res_data    <= '0;
         res_valid   <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync     <= {sync[SYNC_STAGES-2:0], echo_in};
         echo_s_q <= sync[SYNC_STAGES-1];
         mod_q    <= mod;
         case (state)
            ARMED: cnt <= CNT_W'(1);
            COUNT: begin
               cnt    <= cnt + CNT_W'(1);
               sample <= echo_rise ? cnt : TMAX;
               if (!echo_rise && expire) flag <= 1'b1;
            end
            ACCUM: begin
               acc <= acc_nxt;
               n   <= n_inc;
               if (full) begin
                  res_data    <= CNT_W'(acc_nxt >> AVG_LOG2);
                  res_timeout <= flag;
                  res_valid   <= 1'b1;
               end
            end
            default: if (res_ready) begin
               acc       <= '0;
               n         <= '0;
               flag      <= 1'b0;
               res_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mod_phase_meter.sv
// tb_mod_phase_meter: directed checks of delay measurement, averaging, timeout and result handshake
module tb_mod_phase_meter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mod = 1'b0;
   logic        echo_in = 1'b0;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        res_valid, res_timeout, busy;
   int          total = 0;
   int          bad = 0;
   int          busy_cycles = 0;

   mod_phase_meter dut (
      .clk(clk), .rst(rst), .mod(mod), .echo_in(echo_in), .res_ready(res_ready),
      .res_data(res_data), .res_valid(res_valid), .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (busy) busy_cycles++;

   // one mod period of len cycles; echo pulse starting dly cycles after the mod rise, optional extra pulse at pre
   task automatic mod_period(input int dly, input int len, input int pre);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         mod = (i < len / 2);
         echo_in = (dly >= 0 && i >= dly && i < dly + 10) || (pre >= 0 && i >= pre && i < pre + 5);
      end
   endtask

   task automatic handshake();
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", res_valid); end
      total++; if (res_data !== 16'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", res_data); end
      total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0d exp=0", res_timeout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) mod_period(100, 240, -1);
      @(posedge clk); #1 mod = 1'b1;
      repeat (50) @(posedge clk);
      #3;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0d exp=1", busy); end
      rst = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%0d exp=0", busy); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%0d exp=0", res_valid); end
      mod = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) mod_period(100, 240, -1);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL partial_valid got=%0d exp=0", res_valid); end
      mod_period(100, 240, -1);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL fresh_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd102) begin bad++; $display("FAIL fresh_data got=%0d exp=102", res_data); end
      handshake();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL fresh_ack got=%0d exp=0", res_valid); end
   endtask

   task automatic test_basic();
      repeat (4) mod_period(100, 240, -1);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd102) begin bad++; $display("FAIL basic_data got=%0d exp=102", res_data); end
      total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0d exp=0", res_timeout); end
      handshake();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_ack got=%0d exp=0", res_valid); end
   endtask

   task automatic test_average();
      for (int d = 100; d < 104; d++) mod_period(d, 240, -1);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL avg_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd103) begin bad++; $display("FAIL avg_data got=%0d exp=103", res_data); end
      total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL avg_timeout got=%0d exp=0", res_timeout); end
      handshake();
   endtask

   task automatic test_timeout();
      int b0;
      b0 = busy_cycles;
      repeat (4) mod_period(-1, 15050, -1);
      total++; if (busy_cycles - b0 !== 60000) begin bad++; $display("FAIL to_busy got=%0d exp=60000", busy_cycles - b0); end
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL to_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd15000) begin bad++; $display("FAIL to_data got=%0d exp=15000", res_data); end
      total++; if (res_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%0d exp=1", res_timeout); end
      handshake();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL to_ack got=%0d exp=0", res_valid); end
   endtask

   task automatic test_missed_by_mod();
      repeat (8) mod_period(-1, 240, -1);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL miss_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd15000) begin bad++; $display("FAIL miss_data got=%0d exp=15000", res_data); end
      total++; if (res_timeout !== 1'b1) begin bad++; $display("FAIL miss_flag got=%0d exp=1", res_timeout); end
      handshake();
   endtask

   task automatic test_held();
      repeat (4) mod_period(100, 240, -1);
      repeat (3) mod_period(50, 240, 200);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL held_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd102) begin bad++; $display("FAIL held_data got=%0d exp=102", res_data); end
      handshake();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL held_ack got=%0d exp=0", res_valid); end
      repeat (4) mod_period(50, 240, -1);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL next_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd52) begin bad++; $display("FAIL next_data got=%0d exp=52", res_data); end
      #3 rst = 1'b0;
      #1;
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", res_valid); end
      total++; if (res_data !== 16'd0) begin bad++; $display("FAIL rst_data got=%0d exp=0", res_data); end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_ignore();
      repeat (3) mod_period(100, 240, 200);
      mod_period(14998, 15100, -1);
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ign_valid got=%0d exp=1", res_valid); end
      total++; if (res_data !== 16'd3826) begin bad++; $display("FAIL ign_data got=%0d exp=3826", res_data); end
      total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL ign_flag got=%0d exp=0", res_timeout); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_average();
      test_timeout();
      test_missed_by_mod();
      test_held();
      test_ignore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
